// File: rtl/buzzer_seq_if.sv
// Control/status bundle between the game-control FSM (master) and the buzzer sequencer (slave).
// start is a single-cycle request with no ready: the slave samples it on every clk edge and either acts on it or drops it.
interface buzzer_seq_if #(
    parameter int TONE_W = 16,
    parameter int IDX_W  = 3
);
    logic              start;
    logic [7:0]        mode;
    logic [TONE_W-1:0] tone_half;
    logic              buzzer_o;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  beat_idx;
    logic [1:0]        state_dbg;

    modport master (
        output start, mode, tone_half,
        input  buzzer_o, busy, done, beat_idx, state_dbg
    );

    modport slave (
        input  start, mode, tone_half,
        output buzzer_o, busy, done, beat_idx, state_dbg
    );
endinterface

// File: rtl/buzzer_seq.sv
// Programmable-tone buzzer driver: a square wave is gated by a beat pattern and repeated N times or forever.
// All timing is derived from clk by counters; there are no derived clocks.
module buzzer_seq #(
    parameter int                 BEAT_CYCLES = 12500000,
    parameter int                 PAT_LEN     = 8,
    parameter int                 TONE_W      = 16,
    parameter logic [PAT_LEN-1:0] PATTERN_A   = 8'b1111_1111,
    parameter logic [PAT_LEN-1:0] PATTERN_B   = 8'b1010_1010,
    parameter logic [PAT_LEN-1:0] PATTERN_C   = 8'b1110_1110
) (
    input  logic         clk,
    input  logic         RSTn,
    buzzer_seq_if.slave  bus
);
    localparam int IDX_W = $clog2(PAT_LEN);
    localparam int BW    = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [BW-1:0]    BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_n;
    logic [PAT_LEN-1:0]  pat_q, pat_n;
    logic [3:0]          rep_q, rep_n;
    logic [3:0]          reps_q, reps_n;
    logic [TONE_W-1:0]   half_q, half_n;
    logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_n;
    logic                phase_q, phase_n;
    logic [BW-1:0]       beat_cnt_q, beat_cnt_n;
    logic [IDX_W-1:0]    beat_idx_q, beat_idx_n;
    logic                buzzer_q, buzzer_n;

    logic accept, abort, beat_wrap, last_beat;
    logic unused_mode_bits;

    assign unused_mode_bits = ^bus.mode[3:2];
    assign accept    = bus.start & (bus.mode[1:0] != 2'b00);
    assign abort     = bus.start & (bus.mode[1:0] == 2'b00);
    assign beat_wrap = (beat_cnt_q == BEAT_LAST);
    assign last_beat = beat_wrap & (beat_idx_q == IDX_LAST) &
                       (rep_q != 4'd0) & (reps_q == rep_q - 4'd1);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            rep_q      <= '0;
            reps_q     <= '0;
            half_q     <= '0;
            tone_cnt_q <= '0;
            phase_q    <= 1'b0;
            beat_cnt_q <= '0;
            beat_idx_q <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_n;
            pat_q      <= pat_n;
            rep_q      <= rep_n;
            reps_q     <= reps_n;
            half_q     <= half_n;
            tone_cnt_q <= tone_cnt_n;
            phase_q    <= phase_n;
            beat_cnt_q <= beat_cnt_n;
            beat_idx_q <= beat_idx_n;
            buzzer_q   <= buzzer_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        pat_n      = pat_q;
        rep_n      = rep_q;
        reps_n     = reps_q;
        half_n     = half_q;
        tone_cnt_n = tone_cnt_q;
        phase_n    = phase_q;
        beat_cnt_n = beat_cnt_q;
        beat_idx_n = beat_idx_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_n = PLAY;
                    case (bus.mode[1:0])
                        2'b01:   pat_n = PATTERN_A;
                        2'b10:   pat_n = PATTERN_B;
                        default: pat_n = PATTERN_C;
                    endcase
                    rep_n      = bus.mode[7:4];
                    half_n     = (bus.tone_half == '0) ? TONE_W'(1) : bus.tone_half;
                    tone_cnt_n = '0;
                    phase_n    = 1'b1;
                    beat_cnt_n = '0;
                    beat_idx_n = '0;
                    reps_n     = '0;
                end
            end
            PLAY: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    // Tone runs freely across beat boundaries so the pitch stays continuous.
                    if (tone_cnt_q == half_q - TONE_W'(1)) begin
                        tone_cnt_n = '0;
                        phase_n    = ~phase_q;
                    end else begin
                        tone_cnt_n = tone_cnt_q + TONE_W'(1);
                    end
                    if (beat_wrap) begin
                        beat_cnt_n = '0;
                        if (beat_idx_q == IDX_LAST) begin
                            beat_idx_n = '0;
                            reps_n     = reps_q + 4'd1;
                        end else begin
                            beat_idx_n = beat_idx_q + IDX_W'(1);
                        end
                    end else begin
                        beat_cnt_n = beat_cnt_q + BW'(1);
                    end
                    if (last_beat) begin
                        state_n = DONE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Pattern MSB is beat 0; evaluated on next-state values so the pin tracks the state register.
        buzzer_n = (state_n == PLAY) & phase_n & pat_n[IDX_LAST - beat_idx_n];
    end

    assign bus.buzzer_o  = buzzer_q;
    assign bus.busy      = (state_q == PLAY);
    assign bus.done      = (state_q == DONE);
    assign bus.beat_idx  = (state_q == PLAY) ? beat_idx_q : '0;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_buzzer_seq.sv
// Directed bench for buzzer_seq with short beats (4 clk per beat, 8 beats per pattern).
module tb_buzzer_seq;
    logic clk;
    logic RSTn;
    int   total;
    int   bad;

    buzzer_seq_if #(.TONE_W(16), .IDX_W(3)) bus ();

    buzzer_seq #(
        .BEAT_CYCLES(4),
        .PAT_LEN(8),
        .TONE_W(16)
    ) dut (
        .clk (clk),
        .RSTn(RSTn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_buz"},  32'(bus.buzzer_o), 32'd0);
        chk({tag, "_idx"},  32'(bus.beat_idx), 32'd0);
    endtask

    // Expected buzzer at PLAY cycle k (k=1 is the cycle after the accepted start).
    function automatic logic exp_buz(input int k, input int h, input logic [7:0] pat);
        logic ph;
        ph = (((k - 1) / h) % 2) == 0;
        return ph & pat[7 - (((k - 1) / 4) % 8)];
    endfunction

    task automatic play_run(input string tag, input logic [7:0] md, input logic [15:0] th,
                            input logic [7:0] pat, input int h, input int reps, input int poke_at);
        bus.start = 1'b1;
        bus.mode = md;
        bus.tone_half = th;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= reps * 32; k++) begin
            chk($sformatf("%s_busy_c%0d", tag, k), 32'(bus.busy), 32'd1);
            chk($sformatf("%s_done_c%0d", tag, k), 32'(bus.done), 32'd0);
            chk($sformatf("%s_buz_c%0d", tag, k), 32'(bus.buzzer_o), 32'(exp_buz(k, h, pat)));
            chk($sformatf("%s_idx_c%0d", tag, k), 32'(bus.beat_idx), 32'(((k - 1) / 4) % 8));
            if (k == poke_at) begin
                bus.start = 1'b1;
                bus.mode = 8'h02;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd1);
        chk({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done_buz"}, 32'(bus.buzzer_o), 32'd0);
        chk({tag, "_done_idx"}, 32'(bus.beat_idx), 32'd0);
        tick();
        chk_idle({tag, "_after"});
    endtask

    initial begin
        total = 0;
        bad = 0;
        RSTn = 1'b0;
        bus.start = 1'b0;
        bus.mode = 8'h00;
        bus.tone_half = 16'd0;
        tick();
        tick();
        chk_idle("rst");
        chk("rst_state", 32'(bus.state_dbg), 32'd0);
        RSTn = 1'b1;
        tick();
        chk_idle("rst_rel");

        // start with mode 00 while idle does nothing
        bus.start = 1'b1;
        bus.mode = 8'h10;
        bus.tone_half = 16'd2;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_idle($sformatf("idle_stop_%0d", i));
            tick();
        end

        play_run("m01_h2", 8'h11, 16'd2, 8'hFF, 2, 1, 0);
        play_run("m10_h1_r2", 8'h22, 16'd1, 8'hAA, 1, 2, 0);
        play_run("m01_h0", 8'h11, 16'd0, 8'hFF, 1, 1, 0);
        play_run("m01_poke", 8'h1D, 16'd2, 8'hFF, 2, 1, 10);

        // infinite mode 11, then abort
        bus.start = 1'b1;
        bus.mode = 8'h03;
        bus.tone_half = 16'd3;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            chk($sformatf("inf_busy_c%0d", k), 32'(bus.busy), 32'd1);
            chk($sformatf("inf_done_c%0d", k), 32'(bus.done), 32'd0);
            chk($sformatf("inf_buz_c%0d", k), 32'(bus.buzzer_o), 32'(exp_buz(k, 3, 8'hEE)));
            tick();
        end
        bus.start = 1'b1;
        bus.mode = 8'h00;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk_idle($sformatf("abort_%0d", i));
            tick();
        end

        // asynchronous reset mid-play
        bus.start = 1'b1;
        bus.mode = 8'h01;
        bus.tone_half = 16'd2;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < 9; k++) tick();
        chk("mid_pre_buz", 32'(bus.buzzer_o), 32'd1);
        chk("mid_pre_busy", 32'(bus.busy), 32'd1);
        chk("mid_pre_idx", 32'(bus.beat_idx), 32'd2);
        RSTn = 1'b0;
        #1;
        chk_idle("mid_async");
        tick();
        tick();
        chk_idle("mid_held");
        RSTn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle($sformatf("mid_post_%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/buzzer_seq.md
Name: buzzer_seq

Overview:
Parametrised successor to the fixed three-rate buzzer driver. Generates an audible square-wave tone at a programmable frequency, gated by a selectable on/off beat pattern, repeated a programmable number of times or until aborted. Fully synchronous to one clock with no derived clocks. Sits between the game-control FSM (start/mode) and the buzzer pin.

Parameters:
BEAT_CYCLES, 12500000, clk cycles per pattern beat (0.25 s at 50 MHz); must be >= 1
PAT_LEN, 8, beats per pattern (>= 2)
TONE_W, 16, width of tone half-period input
PATTERN_A, 8'b1111_1111, mode 01 pattern (continuous), PAT_LEN bits
PATTERN_B, 8'b1010_1010, mode 10 pattern (alternating beep)
PATTERN_C, 8'b1110_1110, mode 11 pattern (long-long-long, gap)

Ports:
clk  in  1  system clock
RSTn  in  1  reset, asynchronous, active-low
start  in  1  single-cycle request; sampled every clk
mode  in  8  [1:0] pattern select (00 = stop/abort); [7:4] repeat count (0 = infinite); [3:2] reserved, ignored
tone_half  in  TONE_W  tone half-period in clk cycles; latched on accepted start
buzzer_o  out  1  registered buzzer drive
busy  out  1  high in PLAY
done  out  1  one-cycle pulse on normal completion
beat_idx  out  clog2(PAT_LEN)  current beat index, 0 when idle

Behaviour:
- Reset (RSTn low, any time incl. mid-play): state IDLE; buzzer_o=0, busy=0, done=0, beat_idx=0; all counters and latches 0. Takes effect immediately, not clock-gated.
- FSM states: IDLE, PLAY, DONE.
- IDLE: start=1 with mode[1:0]!=00 -> PLAY. Same edge latches the pattern (MSB = beat 0), rep count = mode[7:4], half = max(tone_half,1), and clears tone counter, beat counter, beat_idx and reps-done. Tone phase is set to 1. start with mode[1:0]=00 in IDLE: no effect.
- PLAY, start=1 with mode[1:0]=00: abort. Next state IDLE, buzzer_o=0 next cycle, no done pulse.
- PLAY, start=1 with mode[1:0]!=00: ignored. No restart; latched values unchanged.
- Tone: counter runs 0..half-1. Phase toggles when the counter reaches half-1, then the counter wraps to 0. Tone period = 2*half cycles.
- Beat: counter runs 0..BEAT_CYCLES-1. On wrap, beat_idx increments. On wrap from PAT_LEN-1, beat_idx goes to 0 and reps-done increments.
- Termination: rep count != 0 and the last beat of repetition rep count ends -> DONE. rep count = 0 loops until abort or reset.
- DONE lasts exactly 1 cycle: done=1, busy=0, buzzer_o=0. Then IDLE unconditionally. A start arriving during DONE is ignored.
- buzzer_o register: next value = (state==PLAY) & tone phase & pattern[beat_idx], evaluated on next-state values.
  - First tone-high cycle is the cycle after the accepted start (latency 1).
  - busy rises in the same cycle.
- Beat boundaries do not reset tone phase; the tone is continuous across beats.
- Total PLAY duration for rep count R>0 = R*PAT_LEN*BEAT_CYCLES cycles exactly. done is asserted the following cycle.
- Reserved mode bits never affect behaviour.

Test Plan:
Bench uses BEAT_CYCLES=4, PAT_LEN=8, default patterns.
- Reset mid-play: RSTn low during PLAY -> buzzer_o, busy, done, beat_idx all 0 within the same cycle (asynchronous); after release, outputs stay 0 until a new start.
- Mode 01, tone_half=2, repeat=1: start pulse -> busy=1 next cycle; buzzer_o pattern 1,1,0,0 repeating for exactly 32 cycles; done=1 on cycle 33 for one cycle; then busy=0, buzzer_o=0.
- Mode 10, tone_half=1, repeat=2:
  - buzzer_o toggles every cycle during beats 0,2,4,6 and is 0 during beats 1,3,5,7.
  - beat_idx sequence 0..7 twice.
  - busy high 64 cycles, then a single done pulse.
- Mode 11, repeat=0: plays beyond 100 cycles with no done. Then start with mode=8'h00 -> next cycle busy=0, buzzer_o=0, done never pulses.
- tone_half=0 with mode 01: behaves exactly as tone_half=1 (toggle every cycle).
- Ignored inputs:
  - start with mode=8'h02 during PLAY of a mode-01 run -> pattern, tone and remaining length unchanged.
  - start with mode 00 while IDLE -> no activity.
